byte_stream_packer: RTL and testbench
=====================================

Name: byte_stream_packer

Overview:
Packs a stream of narrow words (default bytes) into a WIDTH*SIZE-bit parallel word, and supersedes the fixed 8x8 byte shifter.
Generalises width, depth and lane order, and adds valid/ready handshakes on both sides.
Supports partial words terminated by in_last, and has a one-word output buffer so collection of the next word continues while the current word waits for downstream.
Sits between a serial byte source (UART/SPI receive) and wide consumers (command decoders, register loaders).

Parameters:
WIDTH, 8, bits per input beat (>=1)
SIZE, 8, beats per packed word (>=2)
MSB_FIRST, 0, 0: beat k lands in lane k (first beat in bits [WIDTH-1:0]); 1: beat k lands in lane SIZE-1-k
CNT_W, $clog2(SIZE+1), width of beat-count fields (derived; not to be overridden)

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous clear: drops the partial word and the output word
in_data  input  WIDTH  input beat
in_valid  input  1  beat present
in_last  input  1  beat terminates the current word (qualified by in_valid)
in_ready  output  1  beat accepted when in_valid && in_ready
out_data  output  WIDTH*SIZE  packed word; unused lanes are 0
out_count  output  CNT_W  number of valid lanes in out_data (1..SIZE)
out_last  output  1  word was terminated by in_last
out_valid  output  1  word present
out_ready  input  1  word consumed when out_valid && out_ready

Behaviour:
- Reset (rst_n=0, asynchronous):
  - out_data=0, out_count=0, out_last=0, out_valid=0.
  - Accumulator and beat count cleared; state=COLLECT.
  - in_ready=0 while rst_n=0.
- Accumulator state machine has two states.
  - COLLECT: in_ready=1 (unless clr=1). An accepted beat writes its lane (index = count, or SIZE-1-count if MSB_FIRST) and increments count. The beat completes the word if count was SIZE-1 or in_last=1.
  - PENDING: the completed word waits for the output slot. in_ready=0.
- Handoff:
  - The output slot is free when !out_valid || out_ready.
  - On a completing beat with the slot free, the word, count and last are registered to the outputs next cycle (latency 1 from the completing beat to out_valid). The accumulator clears and stays in COLLECT. Full throughput: one beat per cycle, no bubbles.
  - On a completing beat with the slot not free, go to PENDING. Leave PENDING on the first cycle the slot is free: transfer, clear, return to COLLECT. Beats resume the cycle after the transfer.
- Output registers:
  - Hold all values while out_valid && !out_ready.
  - On a handshake with no new word arriving, out_valid falls next cycle. out_data/out_count/out_last may hold stale values while out_valid=0.
- Lanes not written in a partial word are 0 in out_data, never stale data from the previous word.
- in_last on the SIZE-th beat gives out_count=SIZE and out_last=1.
- in_last with in_valid=0 is ignored.
- clr=1 (synchronous, priority over everything except rst_n):
  - in_ready=0 that cycle, so no beat is taken.
  - Accumulator and count cleared, state=COLLECT, out_valid=0 next cycle.
  - A simultaneous out handshake is harmless. A word present when clr is asserted is discarded.
- Reset or clr mid-word discards the partial word; no output is produced for it.
- Count arithmetic is CNT_W bits and never wraps: the maximum value SIZE forces completion.

Decomposition:
- Shared package contains:
  - State enum {COLLECT, PENDING}.
  - Function count_width(size)=$clog2(size+1).
  - Function lane_index(k, size, msb_first).
- One sub-module is natural: packer_out_slot. It is the one-word output register with valid/ready and load/hold/clear, and is reusable by future packers.
- The accumulator and FSM stay in the top module.

Test Plan:
- Full word, LSB first (WIDTH=8, SIZE=8), out_ready=1: beats 0x01..0x08 on consecutive cycles -> one cycle after beat 0x08, out_valid=1, out_data=0x0807060504030201, out_count=8, out_last=0; in_ready stays 1 throughout.
- MSB_FIRST=1: same beats -> out_data=0x0102030405060708, out_count=8.
- Partial word: 0xAA, then 0xBB with in_last=1 -> out_data=0x000000000000BBAA, out_count=2, out_last=1; the next word starting 0x11 shows no residue of 0xAA/0xBB in lanes 2..7.
- Backpressure:
  - Setup: out_ready=0, 16 beats 0x01..0x10 offered continuously.
  - First word is held stable.
  - After the 16th beat is accepted, in_ready=0 (PENDING) and no beat 17 is taken.
  - Raise out_ready for one cycle: out_data becomes 0x100F0E0D0C0B0A09, and in_ready=1 on the next cycle.
- Reset and clr:
  - rst_n=0 after 3 beats -> all outputs 0 immediately, without a clock edge; after release, 8 new beats yield only the new word.
  - clr=1 with in_valid=1 and a word pending -> beat not accepted, out_valid=0 next cycle, count restarts at lane 0.

Source files
------------

// File: rtl/byte_stream_packer_pkg.sv
// Shared types and helpers for the byte stream packer.
// Holds the accumulator state enum, count width and lane mapping.
package byte_stream_packer_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        PENDING = 1'b1
    } state_t;

    // Bits needed to hold a count of 0..size.
    function automatic int count_width(input int size);
        return $clog2(size + 1);
    endfunction

    // Lane written by the k-th beat of a word.
    function automatic int lane_index(
        input int k,
        input int size,
        input bit msb_first
    );
        return msb_first ? (size - 1 - k) : k;
    endfunction

endpackage

// File: rtl/byte_stream_packer_if.sv
// Handshake bundle of the byte stream packer.
// master: beat source and word sink; slave: the packer itself.
interface byte_stream_packer_if #(
    parameter int WIDTH = 8,
    parameter int SIZE  = 8,
    parameter int CNT_W = byte_stream_packer_pkg::count_width(SIZE)
);

    logic [WIDTH-1:0]      in_data;
    logic                  in_valid;
    logic                  in_last;
    logic                  in_ready;
    logic [WIDTH*SIZE-1:0] out_data;
    logic [CNT_W-1:0]      out_count;
    logic                  out_last;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_count, out_last, out_valid
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_count, out_last, out_valid
    );

endinterface

// File: rtl/byte_stream_packer_out_slot.sv
// One-word output register with valid/ready: load, hold, clear.
// Ports: clk, rst_n, clr, load + ld_* word, ready in; valid, data, count, last, free out.
module packer_out_slot #(
    parameter int DW = 64,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          load,
    input  logic [DW-1:0] ld_data,
    input  logic [CW-1:0] ld_count,
    input  logic          ld_last,
    input  logic          ready,
    output logic          valid,
    output logic [DW-1:0] data,
    output logic [CW-1:0] count,
    output logic          last,
    output logic          free
);

    // The slot can take a new word when empty or being drained.
    assign free = !valid || ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            count <= '0;
            last  <= 1'b0;
        end else if (clr) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= ld_data;
            count <= ld_count;
            last  <= ld_last;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/byte_stream_packer.sv
// Packs WIDTH-bit beats into WIDTH*SIZE-bit words, valid/ready both sides.
// Ports: clk, rst_n, clr plain; bus (slave) carries in_* beats and out_* words.
module byte_stream_packer
    import byte_stream_packer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int SIZE      = 8,
    parameter bit MSB_FIRST = 1'b0,
    parameter int CNT_W     = count_width(SIZE)
) (
    input logic                 clk,
    input logic                 rst_n,
    input logic                 clr,
    byte_stream_packer_if.slave bus
);

    localparam int DW = WIDTH * SIZE;

    state_t           state;
    logic [DW-1:0]    acc;
    logic [CNT_W-1:0] cnt;
    logic             acc_last;

    logic             accept;
    logic             done;
    logic             slot_free;
    logic [DW-1:0]    acc_wr;
    logic [CNT_W-1:0] cnt_inc;

    logic             ld;
    logic [DW-1:0]    ld_data;
    logic [CNT_W-1:0] ld_count;
    logic             ld_last;

    logic             o_valid;
    logic [DW-1:0]    o_data;
    logic [CNT_W-1:0] o_count;
    logic             o_last;

    assign bus.in_ready = rst_n && !clr && (state == COLLECT);
    assign accept       = bus.in_valid && bus.in_ready;
    assign cnt_inc      = cnt + CNT_W'(1);
    assign done         = accept &&
                          (bus.in_last || cnt == CNT_W'(SIZE - 1));

    // Accumulator with the incoming beat merged into its lane.
    always_comb begin
        acc_wr = acc;
        for (int i = 0; i < SIZE; i++) begin
            if (lane_index(int'(cnt), SIZE, MSB_FIRST) == i)
                acc_wr[i*WIDTH +: WIDTH] = bus.in_data;
        end
    end

    // A completing beat bypasses the accumulator straight into the
    // slot when it is free; a parked word goes out from PENDING.
    always_comb begin
        ld       = 1'b0;
        ld_data  = acc_wr;
        ld_count = cnt_inc;
        ld_last  = bus.in_last;
        if (!clr) begin
            if (state == PENDING) begin
                ld       = slot_free;
                ld_data  = acc;
                ld_count = cnt;
                ld_last  = acc_last;
            end else begin
                ld = done && slot_free;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= COLLECT;
            acc      <= '0;
            cnt      <= '0;
            acc_last <= 1'b0;
        end else if (clr) begin
            state    <= COLLECT;
            acc      <= '0;
            cnt      <= '0;
            acc_last <= 1'b0;
        end else begin
            unique case (state)
                COLLECT: begin
                    if (accept) begin
                        if (done && slot_free) begin
                            acc      <= '0;
                            cnt      <= '0;
                            acc_last <= 1'b0;
                        end else begin
                            acc      <= acc_wr;
                            cnt      <= cnt_inc;
                            acc_last <= bus.in_last;
                            if (done)
                                state <= PENDING;
                        end
                    end
                end
                PENDING: begin
                    if (slot_free) begin
                        state    <= COLLECT;
                        acc      <= '0;
                        cnt      <= '0;
                        acc_last <= 1'b0;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

    packer_out_slot #(
        .DW (DW),
        .CW (CNT_W)
    ) u_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .load     (ld),
        .ld_data  (ld_data),
        .ld_count (ld_count),
        .ld_last  (ld_last),
        .ready    (bus.out_ready),
        .valid    (o_valid),
        .data     (o_data),
        .count    (o_count),
        .last     (o_last),
        .free     (slot_free)
    );

    assign bus.out_valid = o_valid;
    assign bus.out_data  = o_data;
    assign bus.out_count = o_count;
    assign bus.out_last  = o_last;

endmodule

// File: tb/tb_byte_stream_packer.sv
// Scoreboard bench for byte_stream_packer: LSB-first and MSB-first
// instances share one stimulus stream, each checked against its own queue.
module tb_byte_stream_packer;

    typedef struct {
        logic [63:0] d;
        logic [3:0]  c;
        logic        l;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic clr;
    logic [7:0] in_data;
    logic in_valid;
    logic in_last;
    logic out_ready;
    logic rand_rdy;
    logic rdy_force;

    int checks = 0;
    int failures = 0;
    int stalls = 0;

    logic [7:0] part[$];
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    byte_stream_packer_if #(.WIDTH(8), .SIZE(8)) bus0 ();
    byte_stream_packer_if #(.WIDTH(8), .SIZE(8)) bus1 ();

    assign bus0.in_data   = in_data;
    assign bus0.in_valid  = in_valid;
    assign bus0.in_last   = in_last;
    assign bus0.out_ready = out_ready;
    assign bus1.in_data   = in_data;
    assign bus1.in_valid  = in_valid;
    assign bus1.in_last   = in_last;
    assign bus1.out_ready = out_ready;

    byte_stream_packer #(.WIDTH(8), .SIZE(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus0)
    );

    byte_stream_packer #(.WIDTH(8), .SIZE(8), .MSB_FIRST(1'b1)) u_msb (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus1)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Word as the rules define it: beat k into lane k (or 7-k), rest zero.
    function automatic exp_t build(input logic [7:0] b[$], input bit msb,
                                   input logic last);
        exp_t e;
        int lane;
        e.d = '0;
        for (int k = 0; k < b.size(); k++) begin
            lane = msb ? (7 - k) : k;
            e.d[lane*8 +: 8] = b[k];
        end
        e.c = 4'(b.size());
        e.l = last;
        return e;
    endfunction

    // Reference model and monitor, evaluated between active edges.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            part.delete();
            q0.delete();
            q1.delete();
        end else begin
            if (bus0.out_valid && out_ready) begin
                if (q0.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL lsb_unexpected: got %h expected none",
                             bus0.out_data);
                end else begin
                    e = q0.pop_front();
                    chk("lsb_data", bus0.out_data, e.d);
                    chk("lsb_count", 64'(bus0.out_count), 64'(e.c));
                    chk("lsb_last", 64'(bus0.out_last), 64'(e.l));
                end
            end
            if (bus1.out_valid && out_ready) begin
                if (q1.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL msb_unexpected: got %h expected none",
                             bus1.out_data);
                end else begin
                    e = q1.pop_front();
                    chk("msb_data", bus1.out_data, e.d);
                    chk("msb_count", 64'(bus1.out_count), 64'(e.c));
                    chk("msb_last", 64'(bus1.out_last), 64'(e.l));
                end
            end
            if (clr) begin
                part.delete();
                q0.delete();
                q1.delete();
            end else if (in_valid && bus0.in_ready) begin
                part.push_back(in_data);
                if (in_last || part.size() == 8) begin
                    q0.push_back(build(part, 1'b0, in_last));
                    q1.push_back(build(part, 1'b1, in_last));
                    part.delete();
                end
            end
        end
    end

    // Sole driver of out_ready.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_force;
        end
    end

    task automatic send(input logic [7:0] d, input logic l);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        n = 0;
        @(negedge clk);
        while (!bus0.in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got stalled expected accept");
        end
        stalls += n;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0;
        clr = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        in_last = 1'b0;
        rand_rdy = 1'b0;
        rdy_force = 1'b1;
        #3;
        chk("rst_valid", 64'(bus0.out_valid), 64'd0);
        chk("rst_data", bus0.out_data, 64'd0);
        chk("rst_count", 64'(bus0.out_count), 64'd0);
        chk("rst_in_ready", 64'(bus0.in_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full word, both lane orders.
        stalls = 0;
        for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
        chk("full_no_stall", 64'(stalls), 64'd0);
        chk("full_valid", 64'(bus0.out_valid), 64'd1);
        chk("full_data", bus0.out_data, 64'h0807060504030201);
        chk("full_count", 64'(bus0.out_count), 64'd8);
        chk("full_last", 64'(bus0.out_last), 64'd0);
        chk("msb_full_data", bus1.out_data, 64'h0102030405060708);

        // Partial word, then a word that must carry no residue.
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b1);
        chk("part_data", bus0.out_data, 64'h000000000000BBAA);
        chk("part_count", 64'(bus0.out_count), 64'd2);
        chk("part_last", 64'(bus0.out_last), 64'd1);
        for (int i = 1; i <= 8; i++) send(8'(17 * i), 1'b0);
        chk("next_data", bus0.out_data, 64'h8877665544332211);
        repeat (2) @(posedge clk);
        #1;

        // Backpressure: two words, second parks in PENDING.
        rdy_force = 1'b0;
        @(posedge clk);
        #1;
        stalls = 0;
        for (int i = 1; i <= 16; i++) send(8'(i), 1'b0);
        chk("bp_no_stall", 64'(stalls), 64'd0);
        in_valid = 1'b1;
        in_data = 8'h11;
        in_last = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(bus0.in_ready), 64'd0);
            chk("bp_hold", bus0.out_data, 64'h0807060504030201);
        end
        rdy_force = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rdy_force = 1'b0;
        chk("bp_second", bus0.out_data, 64'h100F0E0D0C0B0A09);
        chk("bp_second_valid", 64'(bus0.out_valid), 64'd1);
        @(negedge clk);
        chk("bp_resume", 64'(bus0.in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last = 1'b0;
        rdy_force = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Asynchronous reset mid-word.
        send(8'h21, 1'b0);
        send(8'h22, 1'b0);
        send(8'h23, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(bus0.out_valid), 64'd0);
        chk("arst_data", bus0.out_data, 64'd0);
        chk("arst_count", 64'(bus0.out_count), 64'd0);
        chk("arst_last", 64'(bus0.out_last), 64'd0);
        chk("arst_in_ready", 64'(bus0.in_ready), 64'd0);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) send(8'(8'h30 + i), 1'b0);
        chk("arst_new", bus0.out_data, 64'h3837363534333231);

        // Synchronous clear with a full slot and a parked word.
        rdy_force = 1'b0;
        for (int i = 1; i <= 8; i++) send(8'(8'h40 + i), 1'b0);
        in_valid = 1'b1;
        in_data = 8'h55;
        clr = 1'b1;
        @(negedge clk);
        chk("clr_in_ready", 64'(bus0.in_ready), 64'd0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        in_valid = 1'b0;
        chk("clr_valid", 64'(bus0.out_valid), 64'd0);
        rdy_force = 1'b1;
        send(8'h77, 1'b1);
        chk("clr_lane0", bus0.out_data, 64'h0000000000000077);
        chk("clr_count", 64'(bus0.out_count), 64'd1);
        chk("clr_msb", bus1.out_data, 64'h7700000000000000);

        // Random beats, random gaps, random backpressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            send(8'($urandom), $urandom_range(0, 5) == 0);
        end
        rand_rdy = 1'b0;
        rdy_force = 1'b1;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 50) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        chk("drain_lsb", 64'(q0.size()), 64'd0);
        chk("drain_msb", 64'(q1.size()), 64'd0);
        chk("drain_valid", 64'(bus0.out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
